// File: rtl/decode_imm_sched_pkg.sv
// rtl/decode_imm_sched_pkg.sv - shared constants and types for the decode immediate scheduler
package decode_imm_sched_pkg;

   localparam int INST_TYPE_W = 2;
   localparam int ITYPE_INDEX = 0;
   localparam int UTYPE_INDEX = 1;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_FENCE     = 7'b0001111;

   localparam int IMM_SIGN_BIT = 31;
   localparam int ITYPE_HI     = 31;
   localparam int ITYPE_LO     = 20;
   localparam int UTYPE_HI     = 31;
   localparam int UTYPE_LO     = 12;

   localparam logic BOOL_TRUE  = 1'b1;
   localparam logic BOOL_FALSE = 1'b0;
   localparam int   ZERO       = 0;

   localparam logic [INST_TYPE_W-1:0] TYPE_NONE = 2'b00;
   localparam logic [INST_TYPE_W-1:0] TYPE_I    = 2'b01;
   localparam logic [INST_TYPE_W-1:0] TYPE_U    = 2'b10;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

endpackage

// File: rtl/decode_imm_sched_skid.sv
// rtl/decode_imm_sched_skid.sv - two-entry skid buffer with occupancy FSM and registered handshakes
module decode_imm_skid
   import decode_imm_sched_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   occ_t         occ;
   occ_t         occ_next;
   logic [W-1:0] head;
   logic [W-1:0] skid;
   logic         accept;
   logic         take;
   logic         load_head;
   logic         load_skid;
   logic         head_from_skid;

   assign accept   = in_valid && in_ready;
   assign take     = out_valid && out_ready;
   assign out_data = head;

   always_comb begin
      occ_next       = occ;
      load_head      = BOOL_FALSE;
      load_skid      = BOOL_FALSE;
      head_from_skid = BOOL_FALSE;
      case (occ)
         OCC_EMPTY: begin
            if (accept) begin
               occ_next  = OCC_ONE;
               load_head = BOOL_TRUE;
            end
         end
         OCC_ONE: begin
            if (accept && take) begin
               load_head = BOOL_TRUE;
            end else if (accept) begin
               occ_next  = OCC_FULL;
               load_skid = BOOL_TRUE;
            end else if (take) begin
               occ_next = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (take) begin
               occ_next       = OCC_ONE;
               head_from_skid = BOOL_TRUE;
            end
         end
         default: occ_next = OCC_EMPTY;
      endcase
      // Flush drops everything, including an entry accepted this cycle
      if (flush)
         occ_next = OCC_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= OCC_EMPTY;
         out_valid <= BOOL_FALSE;
         in_ready  <= BOOL_TRUE;
         head      <= '0;
      end else begin
         occ       <= occ_next;
         out_valid <= (occ_next != OCC_EMPTY);
         in_ready  <= (occ_next != OCC_FULL);
         if (head_from_skid)
            head <= skid;
         else if (load_head)
            head <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid)
         skid <= in_data;
   end

endmodule

// File: rtl/instr_sign_ext_aux.sv
// rtl/instr_sign_ext_aux.sv - I/U immediate extraction and sign extension to XLEN
module instr_sign_ext_aux
   import decode_imm_sched_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int INST_W = 32
) (
   input  logic [INST_W-1:0]      instr,
   input  logic [INST_TYPE_W-1:0] instr_type,
   output logic [XLEN-1:0]        imm
);

   logic signed [11:0] i_imm;
   logic signed [31:0] u_imm;

   assign i_imm = instr[ITYPE_HI:ITYPE_LO];
   assign u_imm = {instr[UTYPE_HI:UTYPE_LO], 12'b0};

   // Signed size casts sign-extend; at XLEN=32 the U cast is a no-op
   always_comb begin
      imm = '0;
      if (instr_type[ITYPE_INDEX])
         imm = XLEN'(i_imm);
      else if (instr_type[UTYPE_INDEX])
         imm = XLEN'(u_imm);
   end

endmodule

// File: rtl/decode_imm_sched.sv
// rtl/decode_imm_sched.sv - decode-stage opcode classifier and immediate scheduler toward EX
module decode_imm_sched
   import decode_imm_sched_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int INST_W = 32,
   parameter int PC_W   = XLEN
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_W-1:0]        in_pc,
   input  logic [INST_W-1:0]      in_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [INST_W-1:0]      out_instr,
   output logic [INST_TYPE_W-1:0] out_type,
   output logic [XLEN-1:0]        out_imm,
   output logic                   out_illegal
);

   localparam int PAYLOAD_W = PC_W + INST_W + INST_TYPE_W + XLEN + 1;

   logic [6:0]             opcode;
   logic [INST_TYPE_W-1:0] in_type;
   logic                   in_illegal;
   logic [XLEN-1:0]        in_imm;
   logic [PAYLOAD_W-1:0]   in_data;
   logic [PAYLOAD_W-1:0]   head_data;
   logic [INST_TYPE_W-1:0] head_type;
   logic [XLEN-1:0]        head_imm;
   logic                   head_illegal;

   assign opcode = in_instr[6:0];

   always_comb begin
      in_type    = TYPE_NONE;
      in_illegal = BOOL_FALSE;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: in_type = TYPE_I;
         OPC_LUI, OPC_AUIPC:             in_type = TYPE_U;
         OPC_OP, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_SYSTEM, OPC_FENCE: in_type = TYPE_NONE;
         OPC_OP_IMM_32: begin
            if (XLEN == 64) in_type = TYPE_I;
            else            in_illegal = BOOL_TRUE;
         end
         OPC_OP_32: begin
            if (XLEN != 64) in_illegal = BOOL_TRUE;
         end
         default: in_illegal = BOOL_TRUE;
      endcase
   end

   instr_sign_ext_aux #(
      .XLEN   (XLEN),
      .INST_W (INST_W)
   ) u_sign_ext (
      .instr      (in_instr),
      .instr_type (in_type),
      .imm        (in_imm)
   );

   assign in_data = {in_pc, in_instr, in_type, in_imm, in_illegal};

   decode_imm_skid #(
      .W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_data)
   );

   assign {out_pc, out_instr, head_type, head_imm, head_illegal} = head_data;

   // Stale slot data is hidden so type/imm/illegal read zero when empty
   assign out_type    = out_valid ? head_type : TYPE_NONE;
   assign out_imm     = out_valid ? head_imm  : '0;
   assign out_illegal = out_valid && head_illegal;

endmodule

// File: tb/tb_decode_imm_sched.sv
// tb/tb_decode_imm_sched.sv - directed bench for decode_imm_sched at XLEN=64 and XLEN=32
module tb_decode_imm_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_pc;
   logic [31:0] in_instr;
   logic        out_ready;

   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic [1:0]  out_type;
   logic [63:0] out_imm;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] in_pc32, out_pc32, out_instr32, out_imm32;
   logic [1:0]  out_type32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign in_pc32 = in_pc[31:0];

   decode_imm_sched #(.XLEN(64), .INST_W(32), .PC_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_type(out_type), .out_imm(out_imm),
      .out_illegal(out_illegal)
   );

   decode_imm_sched #(.XLEN(32), .INST_W(32), .PC_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_pc(in_pc32), .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
      .out_pc(out_pc32), .out_instr(out_instr32), .out_type(out_type32), .out_imm(out_imm32),
      .out_illegal(out_illegal32)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_type", 64'(out_type), 64'd0);
      check("rst_out_imm", out_imm, 64'd0);
      check("rst_out_illegal", 64'(out_illegal), 64'd0);
      rst_n = 1'b1;
      step();

      // ADDI x1,x0,-1
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h1000; in_instr = 32'hFFF00093;
      step();
      in_valid = 1'b0;
      check("addi_valid", 64'(out_valid), 64'd1);
      check("addi_pc", out_pc, 64'h1000);
      check("addi_type", 64'(out_type), 64'b01);
      check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_illegal", 64'(out_illegal), 64'd0);
      step();
      check("addi_drained", 64'(out_valid), 64'd0);
      check("empty_imm_zero", out_imm, 64'd0);

      // LUI with bit 31 set, both widths
      in_valid = 1'b1; in_pc = 64'h1004; in_instr = 32'h80000537;
      step();
      in_valid = 1'b0;
      check("lui_type", 64'(out_type), 64'b10);
      check("lui_imm64", out_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui_type32", 64'(out_type32), 64'b10);
      check("lui_imm32", 64'(out_imm32), 64'h8000_0000);
      step();

      // ADDIW: ITYPE on RV64, illegal on RV32
      in_valid = 1'b1; in_pc = 64'h1008; in_instr = 32'hFFF0009B;
      step();
      in_valid = 1'b0;
      check("addiw_type64", 64'(out_type), 64'b01);
      check("addiw_imm64", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addiw_illegal64", 64'(out_illegal), 64'd0);
      check("addiw_illegal32", 64'(out_illegal32), 64'd1);
      check("addiw_type32", 64'(out_type32), 64'd0);
      step();

      // Backpressure: ADD then ADDI 5 fill both slots
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h2000; in_instr = 32'h00B50533;
      step();
      check("bp_one_in_ready", 64'(in_ready), 64'd1);
      check("bp_add_type", 64'(out_type), 64'd0);
      check("bp_add_imm", out_imm, 64'd0);
      check("bp_add_illegal", 64'(out_illegal), 64'd0);
      in_pc = 64'h2004; in_instr = 32'h00500093;
      step();
      in_valid = 1'b0;
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      check("bp_full_head_pc", out_pc, 64'h2000);
      check("bp_full_head_instr", 64'(out_instr), 64'h00B50533);
      out_ready = 1'b1;
      step();
      check("bp_take1_in_ready", 64'(in_ready), 64'd1);
      check("bp_take1_pc", out_pc, 64'h2004);
      check("bp_take1_type", 64'(out_type), 64'b01);
      check("bp_take1_imm", out_imm, 64'd5);
      step();
      check("bp_take2_empty", 64'(out_valid), 64'd0);

      // Streaming: one transfer per cycle
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [11:0] imm12;
         imm12 = 12'(i);
         in_pc = 64'h3000 + 64'(4 * i);
         in_instr = {imm12, 20'h00093};
         step();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_in_ready", 64'(in_ready), 64'd1);
         check("stream_pc", out_pc, 64'h3000 + 64'(4 * i));
         check("stream_imm", out_imm, 64'(i));
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", 64'(out_valid), 64'd0);

      // Flush while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h4000; in_instr = 32'h00100093;
      step();
      in_pc = 64'h4004; in_instr = 32'h00200093;
      step();
      check("fl_full_in_ready", 64'(in_ready), 64'd0);
      flush = 1'b1; in_pc = 64'h4008; in_instr = 32'h00300093;
      step();
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_in_ready", 64'(in_ready), 64'd1);
      // Flush overrides a simultaneous accept
      in_pc = 64'h4100; in_instr = 32'h00400093;
      step();
      check("fl_accept_dropped", 64'(out_valid), 64'd0);
      flush = 1'b0; in_pc = 64'h4200; in_instr = 32'h00500093;
      step();
      in_valid = 1'b0;
      check("fl_next_valid", 64'(out_valid), 64'd1);
      check("fl_next_pc", out_pc, 64'h4200);
      out_ready = 1'b1;
      step();
      check("fl_drained", 64'(out_valid), 64'd0);

      // Illegal opcode, then asynchronous reset while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h5000; in_instr = 32'h0000007F;
      step();
      check("ill_illegal", 64'(out_illegal), 64'd1);
      check("ill_type", 64'(out_type), 64'd0);
      check("ill_imm", out_imm, 64'd0);
      in_pc = 64'h5004; in_instr = 32'hFFF00093;
      step();
      in_valid = 1'b0;
      check("ill_full", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_pc", out_pc, 64'd0);
      check("arst_out_instr", 64'(out_instr), 64'd0);
      check("arst_out_illegal", 64'(out_illegal), 64'd0);
      check("arst_out_imm", out_imm, 64'd0);
      #3;
      rst_n = 1'b1;
      step();
      check("arst_no_survivor", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
